// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback queue: opcode map, FSM encoding and
// the register-write predicate.
package writeback_pkg;

  localparam int unsigned OpLw   = 0;
  localparam int unsigned OpSw   = 1;
  localparam int unsigned OpAdd  = 2;
  localparam int unsigned OpSub  = 3;
  localparam int unsigned OpMul  = 4;
  localparam int unsigned OpDiv  = 5;
  localparam int unsigned OpAnd  = 6;
  localparam int unsigned OpOr   = 7;
  localparam int unsigned OpNot  = 8;
  localparam int unsigned OpCmp  = 9;
  localparam int unsigned OpJmp  = 10;
  localparam int unsigned OpJr   = 11;
  localparam int unsigned OpBeq  = 12;
  localparam int unsigned OpBne  = 13;
  localparam int unsigned OpHalt = 14;
  localparam int unsigned OpNop  = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StGap   = 2'd2
  } wb_state_e;

  // CMP only produces a register result when its option bit is set.
  function automatic logic is_reg_write(input int unsigned opcode, input logic opt);
    case (opcode)
      OpLw, OpAdd, OpSub, OpMul, OpDiv, OpAnd, OpOr, OpNot: return 1'b1;
      OpCmp:                                                return opt;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding pending register writes; storage is exposed so the
// parent can search it for forwarding.
module wb_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             CLOCK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CntW-1:0]  o_count,
  output logic [PtrW-1:0]  o_rd_ptr,
  output logic [WIDTH-1:0] o_entries [DEPTH]
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  always_ff @(posedge CLOCK) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLOCK) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_entries = r_mem;

endmodule

// File: rtl/writeback_queue.sv
// Buffers retiring results and drains them into the register file at most one
// write per SLOT_CYCLES. Define WRITEBACK_QUEUE_FWD_EN to enable forwarding.
module writeback_queue
  import writeback_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RADDR_W     = 5,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SLOT_CYCLES = 6
) (
  input  logic                     CLOCK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [OPC_W-1:0]         OPCD_IN,
  input  logic [RADDR_W-1:0]       ADDR_REG_IN,
  input  logic [DATA_W-1:0]        DATA_IN,
  input  logic                     OPT_BIT_IN,
  output logic                     COND,
  output logic [RADDR_W-1:0]       ADDR_REG_OUT,
  output logic [DATA_W-1:0]        DATA_OUT,
  input  logic [RADDR_W-1:0]       FWD_ADDR,
  output logic                     FWD_HIT,
  output logic [DATA_W-1:0]        FWD_DATA,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [1:0]               ESTADO
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned EntW    = RADDR_W + DATA_W;
  localparam int unsigned GapW    = $clog2(SLOT_CYCLES + 1);
  localparam int unsigned GapLoad = (SLOT_CYCLES > 1) ? SLOT_CYCLES - 2 : 0;

  wb_state_e          r_state;
  wb_state_e          w_state_d;
  logic [GapW-1:0]    r_gap_cnt;
  logic [GapW-1:0]    w_gap_d;
  logic [RADDR_W-1:0] r_addr_out;
  logic [DATA_W-1:0]  r_data_out;

  logic               w_push;
  logic               w_pop;
  logic [EntW-1:0]    w_head;
  logic [CntW-1:0]    w_count;
  logic [PtrW-1:0]    w_rd_ptr;
  logic [EntW-1:0]    w_entries [DEPTH];

  assign IN_READY = (w_count < CntW'(DEPTH));
  // Non-writing opcodes and writes to r0 are consumed without being queued.
  assign w_push   = IN_VALID && IN_READY && is_reg_write(32'(OPCD_IN), OPT_BIT_IN) &&
                    (ADDR_REG_IN != '0);
  assign w_pop    = (w_state_d == StWrite);

  wb_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLOCK     (CLOCK),
    .RST       (RST),
    .i_push    (w_push),
    .i_data    ({ADDR_REG_IN, DATA_IN}),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_rd_ptr  (w_rd_ptr),
    .o_entries (w_entries)
  );

  always_comb begin
    w_state_d = r_state;
    w_gap_d   = r_gap_cnt;
    case (r_state)
      StIdle: begin
        if (w_count != '0) w_state_d = StWrite;
      end
      StWrite: begin
        if (SLOT_CYCLES == 1) begin
          w_state_d = (w_count != '0) ? StWrite : StIdle;
        end else begin
          w_state_d = StGap;
          w_gap_d   = GapW'(GapLoad);
        end
      end
      StGap: begin
        if (r_gap_cnt == '0) w_state_d = (w_count != '0) ? StWrite : StIdle;
        else                 w_gap_d   = r_gap_cnt - GapW'(1);
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RST) begin
      r_state    <= StIdle;
      r_gap_cnt  <= '0;
      r_addr_out <= '0;
      r_data_out <= '0;
    end else begin
      r_state   <= w_state_d;
      r_gap_cnt <= w_gap_d;
      if (w_pop) begin
        r_addr_out <= w_head[EntW-1 -: RADDR_W];
        r_data_out <= w_head[DATA_W-1:0];
      end
    end
  end

  assign COND         = (r_state == StWrite);
  assign ADDR_REG_OUT = r_addr_out;
  assign DATA_OUT     = r_data_out;
  assign COUNT        = w_count;
  assign ESTADO       = r_state;

`ifdef WRITEBACK_QUEUE_FWD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    FWD_HIT  = 1'b0;
    FWD_DATA = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CntW'(k) < w_count) && (FWD_ADDR != '0) &&
          (w_entries[w_rd_ptr + PtrW'(k)][EntW-1 -: RADDR_W] == FWD_ADDR)) begin
        FWD_HIT  = 1'b1;
        FWD_DATA = w_entries[w_rd_ptr + PtrW'(k)][DATA_W-1:0];
      end
    end
  end
`else
  logic w_unused_fwd;

  assign FWD_HIT  = 1'b0;
  assign FWD_DATA = '0;

  always_comb begin
    w_unused_fwd = ^FWD_ADDR ^ ^w_rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_unused_fwd = w_unused_fwd ^ ^w_entries[k];
    end
  end
`endif

endmodule
